// File: rtl/fb_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fb_lut_loader
//  Purpose  : Host write sequencer for the four feedback gain LUTs; single
//             writes and range fills, held off around the beam store window.
//             Optional read-back verification when LUT_READBACK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module fb_lut_loader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 7,
    parameter int RD_LAT     = 2,
    parameter int STRB_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_strb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_fill,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] lut_addrb,
    output logic [DATA_W-1:0] lut_dinb,
    output logic              bpm1_i_lut_web,
    output logic              bpm1_q_lut_web,
    output logic              bpm2_i_lut_web,
    output logic              bpm2_q_lut_web,
    input  logic [DATA_W-1:0] bpm1_i_lut_doutb,
    input  logic [DATA_W-1:0] bpm1_q_lut_doutb,
    input  logic [DATA_W-1:0] bpm2_i_lut_doutb,
    input  logic [DATA_W-1:0] bpm2_q_lut_doutb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int c_guard_w = (STRB_GUARD < 1) ? 1 : $clog2(STRB_GUARD + 1);
    localparam logic [c_guard_w-1:0] c_guard_max = c_guard_w'(STRB_GUARD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GUARD = 3'd1,
        S_WRITE = 3'd2,
        S_NEXT  = 3'd3
`ifdef LUT_READBACK_EN
        , S_READ = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [c_guard_w-1:0]  guard_q, guard_d;
    logic [1:0]            sel_q, sel_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     remain_q, remain_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic                  w_accept;
    logic                  w_guard_ok;
    logic                  w_write;
    logic                  w_rd_done;

    assign w_accept   = cmd_valid && (state_q == S_IDLE);
    assign w_guard_ok = (guard_q == c_guard_max) && !store_strb;

    // Quiet-time counter: any store cycle restarts the hold-off.
    always_comb begin
        guard_d = guard_q;
        if (store_strb) begin
            guard_d = '0;
        end else if (guard_q != c_guard_max) begin
            guard_d = guard_q + c_guard_w'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d  = S_GUARD;
                    sel_d    = cmd_sel;
                    addr_d   = cmd_addr;
                    data_d   = cmd_data;
                    remain_d = (cmd_fill && (cmd_count != '0)) ? cmd_count : ADDR_W'(1);
                end
            end
            S_GUARD: begin
                if (w_guard_ok) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef LUT_READBACK_EN
                state_d = S_READ;
`else
                state_d = S_NEXT;
`endif
            end
`ifdef LUT_READBACK_EN
            S_READ: begin
                if (w_rd_done) begin
                    state_d = S_NEXT;
                end
            end
`endif
            S_NEXT: begin
                remain_d = remain_q - ADDR_W'(1);
                if (remain_q > ADDR_W'(1)) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_GUARD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            guard_q  <= c_guard_max;
            sel_q    <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
        end
    end

    // Address/data registers only move on accept or word advance, so the
    // bus naturally holds its last value while idle.
    assign w_write        = (state_q == S_WRITE);
    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_NEXT) && (remain_q <= ADDR_W'(1));
    assign lut_addrb      = addr_q;
    assign lut_dinb       = data_q;
    assign bpm1_i_lut_web = w_write && (sel_q == 2'd0);
    assign bpm1_q_lut_web = w_write && (sel_q == 2'd1);
    assign bpm2_i_lut_web = w_write && (sel_q == 2'd2);
    assign bpm2_q_lut_web = w_write && (sel_q == 2'd3);

`ifdef LUT_READBACK_EN
    localparam int c_rd_w = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [c_rd_w-1:0] c_rd_last = c_rd_w'(RD_LAT);

    logic [c_rd_w-1:0]  rd_cnt_q, rd_cnt_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [DATA_W-1:0]  w_rd_data;

    always_comb begin
        case (sel_q)
            2'd0:    w_rd_data = bpm1_i_lut_doutb;
            2'd1:    w_rd_data = bpm1_q_lut_doutb;
            2'd2:    w_rd_data = bpm2_i_lut_doutb;
            default: w_rd_data = bpm2_q_lut_doutb;
        endcase
    end

    assign w_rd_done = (state_q == S_READ) && (rd_cnt_q == c_rd_last);

    // Only the first mismatch address of a command is kept.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (w_accept) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        if (state_q == S_WRITE) begin
            rd_cnt_d = '0;
        end else if (state_q == S_READ) begin
            rd_cnt_d = rd_cnt_q + c_rd_w'(1);
            if (w_rd_done && (w_rd_data != data_q)) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_addr_d = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    localparam int c_unused_rd_lat = RD_LAT;
    logic w_unused_doutb;

    assign w_unused_doutb = ^{bpm1_i_lut_doutb, bpm1_q_lut_doutb,
                              bpm2_i_lut_doutb, bpm2_q_lut_doutb};
    assign w_rd_done      = 1'b0;
    assign err            = 1'b0;
    assign err_addr       = '0;
`endif

endmodule
`default_nettype wire
